arm_bus_responder: RTL

Memory-side responder for the multicycle ARM core's unified memory bus (MemWrite/Adr/WriteData/ReadData). It answers every core access with word RAM plus a small memory-mapped register block: a free-running cycle counter and a debug transmit FIFO. The FIFO drains to the testbench or a host over a valid/ready stream. It sits directly under the core top level in the system wrapper, replacing the plain instruction/data memory.

---
 rtl/arm_bus_responder.sv | 133 +++++++++++++
 1 files changed

// File: rtl/arm_bus_responder.sv
// Memory-side responder for the multicycle ARM bus: word RAM, CYCLE counter and debug TX FIFO (ARM_RESP_DBGFIFO_EN).
// Reads are combinational; writes land on the next rising edge. Pushes to a full FIFO are dropped and counted.
// dbg stream is valid/ready with first-word fall-through; the head entry holds while dbg_ready is low.
module arm_bus_responder #(
    parameter int RAM_WORDS  = 64,
    parameter int FIFO_DEPTH = 4
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        MemWrite,
    input  logic [31:0] Adr,
    input  logic [31:0] WriteData,
    output logic [31:0] ReadData,
    output logic        dbg_valid,
    output logic [31:0] dbg_data,
    input  logic        dbg_ready
);
    localparam int AW = $clog2(RAM_WORDS);

    // Register map compared on word address, so Adr[1:0] never matters.
    localparam logic [29:0] A_CYCLE = 30'h2000_0000;
    localparam logic [29:0] A_DBG   = 30'h2000_0001;
    localparam logic [29:0] A_DROP  = 30'h2000_0002;

    logic          w_ram_sel;
    logic          w_cyc_sel;
    logic          w_dbg_sel;
    logic          w_drop_sel;
    logic [AW-1:0] w_ram_idx;
    logic [31:0]   w_stat;
    logic [31:0]   w_drop_rd;
    logic          w_unused;

    logic [31:0]   r_ram [RAM_WORDS];
    logic [31:0]   r_cycle;

    assign w_ram_sel  = (Adr[31:28] == 4'h0);
    assign w_cyc_sel  = (Adr[31:2] == A_CYCLE);
    assign w_dbg_sel  = (Adr[31:2] == A_DBG);
    assign w_drop_sel = (Adr[31:2] == A_DROP);
    assign w_ram_idx  = Adr[AW+1:2];

    // RAM survives reset, so it lives outside the reset domain.
    always_ff @(posedge clk) begin
        if (MemWrite && w_ram_sel) begin
            r_ram[w_ram_idx] <= WriteData;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_cycle <= '0;
        end else if (MemWrite && w_cyc_sel) begin
            r_cycle <= WriteData;
        end else begin
            r_cycle <= r_cycle + 32'd1;
        end
    end

`ifdef ARM_RESP_DBGFIFO_EN
    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;

    logic [31:0]   r_fifo [FIFO_DEPTH];
    logic [PW-1:0] r_wr_ptr;
    logic [PW-1:0] r_rd_ptr;
    logic [CW-1:0] r_count;
    logic [7:0]    r_drop;
    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_push_ok;
    logic          w_pop_ok;

    // Full/empty come from pre-edge occupancy: a push into a full FIFO is lost even if a pop frees a slot.
    assign w_full    = (r_count == CW'(FIFO_DEPTH));
    assign w_empty   = (r_count == '0);
    assign w_push    = MemWrite && w_dbg_sel;
    assign w_push_ok = w_push && !w_full;
    assign w_pop_ok  = dbg_ready && !w_empty;

    always_ff @(posedge clk) begin
        if (w_push_ok) begin
            r_fifo[r_wr_ptr] <= WriteData;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
            r_drop   <= '0;
        end else begin
            if (w_push_ok) begin
                r_wr_ptr <= r_wr_ptr + PW'(1);
            end
            if (w_pop_ok) begin
                r_rd_ptr <= r_rd_ptr + PW'(1);
            end
            r_count <= r_count + CW'(w_push_ok) - CW'(w_pop_ok);
            if (w_push && w_full && (r_drop != 8'hFF)) begin
                r_drop <= r_drop + 8'd1;
            end
        end
    end

    assign dbg_valid = !w_empty;
    assign dbg_data  = w_empty ? 32'd0 : r_fifo[r_rd_ptr];
    assign w_stat    = {30'b0, w_full, w_empty};
    assign w_drop_rd = {24'b0, r_drop};
    assign w_unused  = ^Adr[1:0];
`else
    assign dbg_valid = 1'b0;
    assign dbg_data  = 32'd0;
    assign w_stat    = 32'd1;
    assign w_drop_rd = 32'd0;
    assign w_unused  = ^{dbg_ready, Adr[1:0], (FIFO_DEPTH != 0)};
`endif

    always_comb begin
        ReadData = 32'd0;
        if (w_ram_sel) begin
            ReadData = r_ram[w_ram_idx];
        end else if (w_cyc_sel) begin
            ReadData = r_cycle;
        end else if (w_dbg_sel) begin
            ReadData = w_stat;
        end else if (w_drop_sel) begin
            ReadData = w_drop_rd;
        end
    end
endmodule
